multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Moore control FSM that sequences a shared multi-cycle RV32I datapath: one ALU, one
//  memory port, the register file, and the immediate extender (via out_imm_src).
//  Sits between the instruction register (opcode/funct3) and the datapath muxes.
//  Drives all mux selects and write strobes each cycle.
//  Handles variable-latency memory with a ready handshake and a wait timeout.
// PARAMETERS
//  TIMEOUT_W       4   width of the memory-wait counter
//  TIMEOUT_CYCLES  15  wait cycles without in_mem_ready before abort (<= 2**TIMEOUT_W-1)
// PORTS
//  in_clk           in   1  clock; all state updates on its rising edge
//  in_rst           in   1  reset; asynchronous, active-high
//  in_opcode        in   7  IR[6:0]
//  in_funct3        in   3  IR[14:12]
//  in_zero          in   1  ALU result == 0
//  in_lt / in_ltu   in   1  signed / unsigned rs1 < rs2 from the ALU compare
//  in_mem_ready     in   1  memory completes the current request this cycle
//  out_mem_req      out  1  memory request valid
//  out_mem_write    out  1  request is a store
//  out_adr_src      out  1  0 = PC, 1 = ALUOut
//  out_ir_write     out  1  latch instruction and old PC
//  out_pc_write     out  1  PC <= result bus
//  out_reg_write    out  1  rd <= result bus
//  out_alu_src_a    out  2  0 PC, 1 OLDPC, 2 rs1, 3 ZERO
//  out_alu_src_b    out  2  0 rs2, 1 IMM, 2 const 4
//  out_alu_op       out  2  0 ADD, 1 SUB, 2 FUNCT (decoded from funct3/funct7)
//  out_result_src   out  2  0 ALUOut, 1 mem data, 2 ALU result
//  out_imm_src      out  3  0 I, 1 S, 2 B, 3 J, 4 U
//  out_illegal      out  1  one-cycle pulse: unsupported opcode
//  out_bus_err      out  1  one-cycle pulse: memory wait timeout
//  out_state        out  4  current state (debug)
// BEHAVIOUR
//  Reset: state FETCH, wait counter 0; while in_rst=1, all strobes/pulses 0, selects 0.
//  Reset mid-operation: aborts immediately; a pending store is dropped.
//  Handshake: out_mem_req (and out_mem_write) are held stable until in_mem_ready.
//   Counter clears on ready or state exit; increments each non-ready cycle.
//   Reaching TIMEOUT_CYCLES: out_bus_err pulse, counter cleared, next state FETCH.
//  FETCH: req, adr PC, a=PC, b=4, ADD, result=ALU result.
//   On ready: ir_write=1, pc_write=1 -> DECODE; a FETCH timeout does not advance PC.
//  DECODE: a=OLDPC, b=IMM, ADD (target into ALUOut); imm_src chosen by opcode.
//   Next: ld/st->MEMADR, R->EXECR, I-arith->EXECI, B->BRANCH, JAL->JAL, JALR->JALR,
//   LUI->LUI, AUIPC->AUIPC; other opcodes -> out_illegal pulse, FETCH.
//  MEMADR: a=rs1, b=IMM, ADD; imm_src I for loads, S for stores -> MEMREAD / MEMWRITE.
//  MEMREAD: req, adr ALUOut -> MEMWB on ready.
//  MEMWRITE: req + write, adr ALUOut -> FETCH on ready.
//  MEMWB: result=data, reg_write -> FETCH.
//  EXECR: a=rs1, b=rs2, FUNCT -> ALUWB.
//  EXECI: a=rs1, b=IMM (imm_src I), FUNCT -> ALUWB.
//  ALUWB: result=ALUOut, reg_write -> FETCH.
//  BRANCH: a=rs1, b=rs2, SUB, result=ALUOut, pc_write=taken -> FETCH.
//   taken: f3 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011 never.
//  JALR: a=rs1, b=IMM (I), ADD -> JAL.
//  JAL: pc_write, result=ALUOut; a=OLDPC, b=4, ADD -> ALUWB (rd=OLDPC+4, rd==rs1 safe).
//  LUI: a=ZERO, b=IMM (U) -> ALUWB.
//  AUIPC: a=OLDPC, b=IMM (U) -> ALUWB.
//  All arithmetic is 32-bit wrap in the datapath; the FSM never inspects operand values.
// CONFIGURATION
//  CTRL_ENV_HALT_EN defined:
//   opcode 1110011 -> HALT: all strobes 0; out_state=HALT; exits only via in_rst.
//  CTRL_ENV_HALT_EN undefined:
//   opcode 1110011 is illegal (out_illegal pulse, return to FETCH).
// STRUCTURE
//  riscv_ctrl_pkg: opcode localparams, state encodings, src_a/src_b/result/alu_op/imm_src codes.
//  Sub-module branch_cond: funct3 + zero/lt/ltu -> taken (combinational).
// TESTING
//  ready held 1; addi x1,x0,5 -> FETCH,DECODE,EXECI,ALUWB; reg_write in cycle 4 only.
//  FETCH with ready low 3 cycles -> req held 4 cycles; ir_write only on the ready cycle.
//  ready never high -> out_bus_err pulses at cycle 15; FETCH repeats; pc_write never set.
//  beq: zero=1 -> pc_write=1 in BRANCH; bne, zero=1 -> pc_write=0.
//  sw, in_rst pulsed mid-MEMWRITE -> state FETCH; mem_write=0 in the same cycle.
//  opcode 1110011 -> HALT held if CTRL_ENV_HALT_EN, else out_illegal pulse then FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states
// and the mux-select codes driven into the datapath.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALR     = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_HALT     = 4'd14
    } state_e;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            OP_LUI, OP_AUIPC:  return IMM_U;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch-taken decision from funct3 and the ALU compare flags.
module branch_cond
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] in_funct3,
    input  logic       in_zero,
    input  logic       in_lt,
    input  logic       in_ltu,
    output logic       out_taken
);

    always_comb begin
        out_taken = 1'b0;
        case (in_funct3)
            3'b000:  out_taken = in_zero;
            3'b001:  out_taken = ~in_zero;
            3'b100:  out_taken = in_lt;
            3'b101:  out_taken = ~in_lt;
            3'b110:  out_taken = in_ltu;
            3'b111:  out_taken = ~in_ltu;
            default: out_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for a shared multi-cycle RV32I datapath with a memory-wait timeout.
// Build option CTRL_ENV_HALT_EN turns the SYSTEM opcode into a sticky HALT state.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W      = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic [6:0] in_opcode,
    input  logic [2:0] in_funct3,
    input  logic       in_zero,
    input  logic       in_lt,
    input  logic       in_ltu,
    input  logic       in_mem_ready,
    output logic       out_mem_req,
    output logic       out_mem_write,
    output logic       out_adr_src,
    output logic       out_ir_write,
    output logic       out_pc_write,
    output logic       out_reg_write,
    output logic [1:0] out_alu_src_a,
    output logic [1:0] out_alu_src_b,
    output logic [1:0] out_alu_op,
    output logic [1:0] out_result_src,
    output logic [2:0] out_imm_src,
    output logic       out_illegal,
    output logic       out_bus_err,
    output logic [3:0] out_state
);

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic                 taken;

    branch_cond u_branch_cond (
        .in_funct3 (in_funct3),
        .in_zero   (in_zero),
        .in_lt     (in_lt),
        .in_ltu    (in_ltu),
        .out_taken (taken)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_d         = '0;
        out_mem_req    = 1'b0;
        out_mem_write  = 1'b0;
        out_adr_src    = 1'b0;
        out_ir_write   = 1'b0;
        out_pc_write   = 1'b0;
        out_reg_write  = 1'b0;
        out_alu_src_a  = SRCA_PC;
        out_alu_src_b  = SRCB_RS2;
        out_alu_op     = ALU_ADD;
        out_result_src = RES_ALUOUT;
        out_imm_src    = IMM_I;
        out_illegal    = 1'b0;
        out_bus_err    = 1'b0;

        // Memory states share the wait counter: stay put until ready or timeout.
        if (state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE} && !in_mem_ready) begin
            if (wait_q == TMO_LAST) begin
                out_bus_err = 1'b1;
                state_d     = S_FETCH;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        case (state_q)
            S_FETCH: begin
                out_mem_req    = 1'b1;
                out_alu_src_b  = SRCB_FOUR;
                out_result_src = RES_ALU;
                if (in_mem_ready) begin
                    out_ir_write = 1'b1;
                    out_pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                out_alu_src_a = SRCA_OLDPC;
                out_alu_src_b = SRCB_IMM;
                out_imm_src   = imm_src_for(in_opcode);
                case (in_opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_OP:             state_d = S_EXECR;
                    OP_OPIMM:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
`ifdef CTRL_ENV_HALT_EN
                    OP_SYSTEM:         state_d = S_HALT;
`endif
                    default: begin
                        out_illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                out_alu_src_a = SRCA_RS1;
                out_alu_src_b = SRCB_IMM;
                out_imm_src   = (in_opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d       = (in_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                out_mem_req = 1'b1;
                out_adr_src = 1'b1;
                if (in_mem_ready) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                out_mem_req   = 1'b1;
                out_mem_write = 1'b1;
                out_adr_src   = 1'b1;
                if (in_mem_ready) state_d = S_FETCH;
            end
            S_MEMWB: begin
                out_result_src = RES_MEM;
                out_reg_write  = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXECR: begin
                out_alu_src_a = SRCA_RS1;
                out_alu_op    = ALU_FUNCT;
                state_d       = S_ALUWB;
            end
            S_EXECI: begin
                out_alu_src_a = SRCA_RS1;
                out_alu_src_b = SRCB_IMM;
                out_alu_op    = ALU_FUNCT;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                out_reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                out_alu_src_a = SRCA_RS1;
                out_alu_op    = ALU_SUB;
                out_imm_src   = IMM_B;
                out_pc_write  = taken;
                state_d       = S_FETCH;
            end
            S_JALR: begin
                out_alu_src_a = SRCA_RS1;
                out_alu_src_b = SRCB_IMM;
                state_d       = S_JAL;
            end
            // ALUOut holds the target here; OLDPC+4 is formed now so rd==rs1 is safe.
            S_JAL: begin
                out_pc_write  = 1'b1;
                out_alu_src_a = SRCA_OLDPC;
                out_alu_src_b = SRCB_FOUR;
                state_d       = S_ALUWB;
            end
            S_LUI: begin
                out_alu_src_a = SRCA_ZERO;
                out_alu_src_b = SRCB_IMM;
                out_imm_src   = IMM_U;
                state_d       = S_ALUWB;
            end
            S_AUIPC: begin
                out_alu_src_a = SRCA_OLDPC;
                out_alu_src_b = SRCB_IMM;
                out_imm_src   = IMM_U;
                state_d       = S_ALUWB;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset silences every strobe at once, dropping any in-flight store.
        if (in_rst) begin
            out_mem_req    = 1'b0;
            out_mem_write  = 1'b0;
            out_adr_src    = 1'b0;
            out_ir_write   = 1'b0;
            out_pc_write   = 1'b0;
            out_reg_write  = 1'b0;
            out_alu_src_a  = '0;
            out_alu_src_b  = '0;
            out_alu_op     = '0;
            out_result_src = '0;
            out_imm_src    = '0;
            out_illegal    = 1'b0;
            out_bus_err    = 1'b0;
        end
    end

    assign out_state = state_q;

endmodule
